// File: rtl/traffic_sink.sv
// traffic_sink: ejection-side endpoint for one router. Accepts flits from the
// local output port, tracks per-VC packet framing, checks the destination,
// counts flits and packets, and returns credits after a programmable delay.
// Optional feature macro: SINK_PKTLEN_CHECK_EN (per-VC packet length check
// plus a max_pkt_len output).
module traffic_sink #(
    parameter int unsigned NUM_VC           = 4,
    parameter int unsigned VC_BITS          = 2,
    parameter int unsigned DST_BITS         = 6,
    parameter int unsigned CNT_BITS         = 16,
    parameter int unsigned MAX_CREDIT_DELAY = 8,
    parameter int unsigned DLY_BITS         = 4
`ifdef SINK_PKTLEN_CHECK_EN
   ,parameter int unsigned MAX_PKT_FLITS    = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [DST_BITS-1:0] cfg_node_id,
    input  logic [CNT_BITS-1:0] cfg_expected,
    input  logic [DLY_BITS-1:0] cfg_credit_delay,
    input  logic                in_valid,
    input  logic [VC_BITS-1:0]  in_vc,
    input  logic                in_head,
    input  logic                in_tail,
    input  logic [DST_BITS-1:0] in_dst,
    output logic                cr_valid,
    output logic [VC_BITS-1:0]  cr_vc,
    output logic [CNT_BITS-1:0] flit_count,
    output logic [CNT_BITS-1:0] pkt_count,
    output logic                done,
    output logic                err,
    output logic [2:0]          err_code
`ifdef SINK_PKTLEN_CHECK_EN
   ,output logic [CNT_BITS-1:0] max_pkt_len
`endif
);

    typedef enum logic [1:0] {ST_UNCFG, ST_RUN, ST_DONE} top_state_t;
    typedef enum logic {VC_IDLE, VC_BODY} vc_state_t;

    localparam logic [2:0]          ERR_NONE  = 3'd0;
    localparam logic [2:0]          ERR_UNCFG = 3'd1;
    localparam logic [2:0]          ERR_NOHEAD = 3'd2;
    localparam logic [2:0]          ERR_REHEAD = 3'd3;
    localparam logic [2:0]          ERR_DST   = 3'd4;
    localparam logic [2:0]          ERR_EXTRA = 3'd5;
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [DLY_BITS-1:0] DLY_MAX   = DLY_BITS'(MAX_CREDIT_DELAY);

    top_state_t          state_q, state_d;
    vc_state_t           vc_st_q [NUM_VC];
    vc_state_t           vc_st_d [NUM_VC];
    vc_state_t           cur;
    logic [DST_BITS-1:0] node_id_q, node_id_d;
    logic [CNT_BITS-1:0] expected_q, expected_d;
    logic [DLY_BITS-1:0] dly_q, dly_d, eff_dly, ins_idx;
    logic                dl_vld_q [MAX_CREDIT_DELAY];
    logic                dl_vld_d [MAX_CREDIT_DELAY];
    logic [VC_BITS-1:0]  dl_vc_q  [MAX_CREDIT_DELAY];
    logic [VC_BITS-1:0]  dl_vc_d  [MAX_CREDIT_DELAY];
    logic [CNT_BITS-1:0] flit_count_d, pkt_count_d;
    logic                done_d, err_d, cr_valid_d, accept, pkt_done;
    logic [2:0]          err_code_d, flit_err;
    logic [VC_BITS-1:0]  cr_vc_d;
`ifdef SINK_PKTLEN_CHECK_EN
    localparam logic [2:0] ERR_LEN = 3'd6;
    logic [CNT_BITS-1:0] len_q [NUM_VC];
    logic [CNT_BITS-1:0] len_d [NUM_VC];
    logic [CNT_BITS-1:0] new_len, max_len_d;
    logic                too_long;
`endif

    // Next-state, counters, error capture and credit delay line
    always_comb begin
        state_d      = state_q;
        vc_st_d      = vc_st_q;
        node_id_d    = node_id_q;
        expected_d   = expected_q;
        dly_d        = dly_q;
        flit_count_d = flit_count;
        pkt_count_d  = pkt_count;
        err_d        = err;
        err_code_d   = err_code;
        pkt_done     = 1'b0;
        flit_err     = ERR_NONE;
        cur          = vc_st_q[in_vc];
        // Flits coinciding with cfg_load belong to neither configuration
        accept       = in_valid && !cfg_load && (state_q != ST_UNCFG);
        eff_dly      = (cfg_credit_delay == '0)     ? DLY_BITS'(1) :
                       (cfg_credit_delay > DLY_MAX) ? DLY_MAX : cfg_credit_delay;
        ins_idx      = dly_q - DLY_BITS'(1);
`ifdef SINK_PKTLEN_CHECK_EN
        len_d        = len_q;
        max_len_d    = max_pkt_len;
        new_len      = '0;
        too_long     = 1'b0;
`endif

        // Delay line shifts toward slot 0; a new credit enters at slot D-1
        for (int i = 0; i < int'(MAX_CREDIT_DELAY) - 1; i++) begin
            dl_vld_d[i] = dl_vld_q[i+1];
            dl_vc_d[i]  = dl_vc_q[i+1];
        end
        dl_vld_d[MAX_CREDIT_DELAY-1] = 1'b0;
        dl_vc_d[MAX_CREDIT_DELAY-1]  = '0;
        if (accept) begin
            for (int i = 0; i < int'(MAX_CREDIT_DELAY); i++) begin
                if (DLY_BITS'(i) == ins_idx) begin
                    dl_vld_d[i] = 1'b1;
                    dl_vc_d[i]  = in_vc;
                end
            end
        end
        cr_valid_d = dl_vld_q[0];
        cr_vc_d    = dl_vld_q[0] ? dl_vc_q[0] : '0;

        // Per-VC framing and error classification (lowest code wins)
        if (in_valid && !cfg_load) begin
            if (state_q == ST_UNCFG) begin
                flit_err = ERR_UNCFG;
            end else begin
                case (cur)
                    VC_IDLE: begin
                        if (in_head) begin
                            if (in_tail) pkt_done = 1'b1;
                            else         vc_st_d[in_vc] = VC_BODY;
                        end
                    end
                    VC_BODY: begin
                        if (in_tail) begin
                            pkt_done       = 1'b1;
                            vc_st_d[in_vc] = VC_IDLE;
                        end
                    end
                    default: vc_st_d[in_vc] = VC_IDLE;
                endcase
`ifdef SINK_PKTLEN_CHECK_EN
                if (in_head)
                    new_len = CNT_BITS'(1);
                else if (cur == VC_BODY)
                    new_len = (len_q[in_vc] == CNT_MAX) ? CNT_MAX : len_q[in_vc] + CNT_BITS'(1);
                else
                    new_len = len_q[in_vc];
                too_long     = new_len > CNT_BITS'(MAX_PKT_FLITS);
                len_d[in_vc] = pkt_done ? '0 : new_len;
                if (pkt_done && (new_len > max_pkt_len)) max_len_d = new_len;
`endif
                if (cur == VC_IDLE && !in_head)            flit_err = ERR_NOHEAD;
                else if (cur == VC_BODY && in_head)        flit_err = ERR_REHEAD;
                else if (in_head && in_dst != node_id_q)   flit_err = ERR_DST;
                else if (state_q == ST_DONE)               flit_err = ERR_EXTRA;
`ifdef SINK_PKTLEN_CHECK_EN
                else if (too_long)                         flit_err = ERR_LEN;
`endif
                flit_count_d = (flit_count == CNT_MAX) ? flit_count : flit_count + CNT_BITS'(1);
                if (pkt_done)
                    pkt_count_d = (pkt_count == CNT_MAX) ? pkt_count : pkt_count + CNT_BITS'(1);
            end
        end
        if (flit_err != ERR_NONE && !err) begin
            err_d      = 1'b1;
            err_code_d = flit_err;
        end

        // Top FSM
        case (state_q)
            ST_UNCFG: state_d = ST_UNCFG;
            ST_RUN:   if (pkt_count >= expected_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_UNCFG;
        endcase

        // Configuration load restarts everything; a new delay flushes credits
        if (cfg_load) begin
            state_d      = ST_RUN;
            node_id_d    = cfg_node_id;
            expected_d   = cfg_expected;
            dly_d        = eff_dly;
            flit_count_d = '0;
            pkt_count_d  = '0;
            err_d        = 1'b0;
            err_code_d   = ERR_NONE;
            for (int v = 0; v < int'(NUM_VC); v++) vc_st_d[v] = VC_IDLE;
`ifdef SINK_PKTLEN_CHECK_EN
            for (int v = 0; v < int'(NUM_VC); v++) len_d[v] = '0;
            max_len_d = '0;
`endif
            if (eff_dly != dly_q) begin
                for (int i = 0; i < int'(MAX_CREDIT_DELAY); i++) begin
                    dl_vld_d[i] = 1'b0;
                    dl_vc_d[i]  = '0;
                end
                cr_valid_d = 1'b0;
                cr_vc_d    = '0;
            end
        end
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_UNCFG;
            node_id_q  <= '0;
            expected_q <= '0;
            dly_q      <= DLY_BITS'(1);
            flit_count <= '0;
            pkt_count  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            cr_valid   <= 1'b0;
            cr_vc      <= '0;
            for (int v = 0; v < int'(NUM_VC); v++) vc_st_q[v] <= VC_IDLE;
            for (int i = 0; i < int'(MAX_CREDIT_DELAY); i++) begin
                dl_vld_q[i] <= 1'b0;
                dl_vc_q[i]  <= '0;
            end
`ifdef SINK_PKTLEN_CHECK_EN
            for (int v = 0; v < int'(NUM_VC); v++) len_q[v] <= '0;
            max_pkt_len <= '0;
`endif
        end else begin
            state_q    <= state_d;
            node_id_q  <= node_id_d;
            expected_q <= expected_d;
            dly_q      <= dly_d;
            flit_count <= flit_count_d;
            pkt_count  <= pkt_count_d;
            done       <= done_d;
            err        <= err_d;
            err_code   <= err_code_d;
            cr_valid   <= cr_valid_d;
            cr_vc      <= cr_vc_d;
            for (int v = 0; v < int'(NUM_VC); v++) vc_st_q[v] <= vc_st_d[v];
            for (int i = 0; i < int'(MAX_CREDIT_DELAY); i++) begin
                dl_vld_q[i] <= dl_vld_d[i];
                dl_vc_q[i]  <= dl_vc_d[i];
            end
`ifdef SINK_PKTLEN_CHECK_EN
            for (int v = 0; v < int'(NUM_VC); v++) len_q[v] <= len_d[v];
            max_pkt_len <= max_len_d;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_sink.sv
// Directed, table-driven bench for traffic_sink.
module tb_traffic_sink;
    localparam int unsigned NUM_VC = 4, VC_BITS = 2, DST_BITS = 6;
    localparam int unsigned CNT_BITS = 16, MAX_CREDIT_DELAY = 8, DLY_BITS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, cfg_load, in_valid, in_head, in_tail;
    logic [DST_BITS-1:0] cfg_node_id, in_dst;
    logic [CNT_BITS-1:0] cfg_expected;
    logic [DLY_BITS-1:0] cfg_credit_delay;
    logic [VC_BITS-1:0]  in_vc;
    logic                cr_valid, done, err;
    logic [VC_BITS-1:0]  cr_vc;
    logic [CNT_BITS-1:0] flit_count, pkt_count;
    logic [2:0]          err_code;
`ifdef SINK_PKTLEN_CHECK_EN
    logic [CNT_BITS-1:0] max_pkt_len;
`endif

    traffic_sink #(
        .NUM_VC(NUM_VC), .VC_BITS(VC_BITS), .DST_BITS(DST_BITS), .CNT_BITS(CNT_BITS),
        .MAX_CREDIT_DELAY(MAX_CREDIT_DELAY), .DLY_BITS(DLY_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_node_id(cfg_node_id),
        .cfg_expected(cfg_expected), .cfg_credit_delay(cfg_credit_delay),
        .in_valid(in_valid), .in_vc(in_vc), .in_head(in_head), .in_tail(in_tail),
        .in_dst(in_dst), .cr_valid(cr_valid), .cr_vc(cr_vc), .flit_count(flit_count),
        .pkt_count(pkt_count), .done(done), .err(err), .err_code(err_code)
`ifdef SINK_PKTLEN_CHECK_EN
       ,.max_pkt_len(max_pkt_len)
`endif
    );

    // One vector: flit inputs, then outputs expected after the edge that samples them
    typedef struct {
        int v, vc, h, t, dst;
        int crv, crvc, fc, pc, dn, er, code;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input int vc, input int h, input int t, input int dst);
        in_valid = v[0];
        in_vc    = VC_BITS'(vc);
        in_head  = h[0];
        in_tail  = t[0];
        in_dst   = DST_BITS'(dst);
    endtask

    function automatic vec_t row(input int v, input int vc, input int h, input int t,
                                 input int dst, input int crv, input int crvc, input int fc,
                                 input int pc, input int dn, input int er, input int code);
        vec_t r;
        r.v = v; r.vc = vc; r.h = h; r.t = t; r.dst = dst;
        r.crv = crv; r.crvc = crvc; r.fc = fc; r.pc = pc; r.dn = dn; r.er = er; r.code = code;
        return r;
    endfunction

    task automatic run_table(input string tag);
        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].vc, vt[i].h, vt[i].t, vt[i].dst);
            step();
            chk($sformatf("%s[%0d].cr_valid", tag, i), int'(cr_valid), vt[i].crv);
            chk($sformatf("%s[%0d].cr_vc", tag, i), int'(cr_vc), vt[i].crvc);
            chk($sformatf("%s[%0d].flit_count", tag, i), int'(flit_count), vt[i].fc);
            chk($sformatf("%s[%0d].pkt_count", tag, i), int'(pkt_count), vt[i].pc);
            chk($sformatf("%s[%0d].done", tag, i), int'(done), vt[i].dn);
            chk($sformatf("%s[%0d].err", tag, i), int'(err), vt[i].er);
            chk($sformatf("%s[%0d].err_code", tag, i), int'(err_code), vt[i].code);
        end
        drive(0, 0, 0, 0, 0);
        vt.delete();
    endtask

    task automatic cfg(input int node, input int expct, input int dly);
        drive(0, 0, 0, 0, 0);
        cfg_load         = 1'b1;
        cfg_node_id      = DST_BITS'(node);
        cfg_expected     = CNT_BITS'(expct);
        cfg_credit_delay = DLY_BITS'(dly);
        step();
        cfg_load = 1'b0;
        chk("cfg.flit_count", int'(flit_count), 0);
        chk("cfg.pkt_count", int'(pkt_count), 0);
        chk("cfg.err", int'(err), 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_node_id = '0; cfg_expected = '0;
        cfg_credit_delay = '0;
        drive(0, 0, 0, 0, 0);
        step(); step();
        chk("rst.cr_valid", int'(cr_valid), 0);
        chk("rst.cr_vc", int'(cr_vc), 0);
        chk("rst.flit_count", int'(flit_count), 0);
        chk("rst.pkt_count", int'(pkt_count), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.err", int'(err), 0);
        chk("rst.err_code", int'(err_code), 0);
        rst_n = 1'b1;

        // Flit before any configuration: dropped, no credit, code 1
        vt.push_back(row(1, 1, 1, 1, 5,  0, 0, 0, 0, 0, 1, 1));
        vt.push_back(row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
        vt.push_back(row(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1));
        run_table("uncfg");

        // node 5, expect 2, D=3: 3-flit packet on VC1 then 1-flit packet on VC2
        cfg(5, 2, 3);
        vt.push_back(row(1, 1, 1, 0, 5,  0, 0, 1, 0, 0, 0, 0));
        vt.push_back(row(1, 1, 0, 0, 5,  0, 0, 2, 0, 0, 0, 0));
        vt.push_back(row(1, 1, 0, 1, 5,  0, 0, 3, 1, 0, 0, 0));
        vt.push_back(row(1, 2, 1, 1, 5,  1, 1, 4, 2, 0, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 1, 4, 2, 1, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 1, 4, 2, 1, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 2, 4, 2, 1, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  0, 0, 4, 2, 1, 0, 0));
        run_table("basic");

        // D=0 behaves as 1; VC0 and VC3 interleaved every cycle
        cfg(5, 2, 0);
        vt.push_back(row(1, 0, 1, 0, 5,  0, 0, 1, 0, 0, 0, 0));
        vt.push_back(row(1, 3, 1, 0, 5,  1, 0, 2, 0, 0, 0, 0));
        vt.push_back(row(1, 0, 0, 0, 5,  1, 3, 3, 0, 0, 0, 0));
        vt.push_back(row(1, 3, 0, 0, 5,  1, 0, 4, 0, 0, 0, 0));
        vt.push_back(row(1, 0, 0, 1, 5,  1, 3, 5, 1, 0, 0, 0));
        vt.push_back(row(1, 3, 0, 1, 5,  1, 0, 6, 2, 0, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 3, 6, 2, 1, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  0, 0, 6, 2, 1, 0, 0));
        run_table("interleave");

        // Body on idle VC2 then head with wrong dst: first error (2) sticks
        cfg(5, 4, 1);
        vt.push_back(row(1, 2, 0, 0, 0,  0, 0, 1, 0, 0, 1, 2));
        vt.push_back(row(1, 1, 1, 1, 7,  1, 2, 2, 1, 0, 1, 2));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 1, 2, 1, 0, 1, 2));
        run_table("proto");

        // Extra packet after done: code 5, credited, pkt_count = expected+1
        cfg(5, 1, 1);
        vt.push_back(row(1, 0, 1, 1, 5,  0, 0, 1, 1, 0, 0, 0));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 0, 0));
        vt.push_back(row(1, 2, 1, 1, 5,  0, 0, 2, 2, 1, 1, 5));
        vt.push_back(row(0, 0, 0, 0, 0,  1, 2, 2, 2, 1, 1, 5));
        run_table("extra");

        // D=15 clamps to 8 cycles
        cfg(5, 10, 15);
        drive(1, 3, 1, 0, 5);
        step();
        drive(0, 0, 0, 0, 0);
        chk("d15.k0.cr_valid", int'(cr_valid), 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("d15.k%0d.cr_valid", k), int'(cr_valid), (k == 8) ? 1 : 0);
            if (k == 8) chk("d15.k8.cr_vc", int'(cr_vc), 3);
        end

        // Reset with three credits in flight: none may emerge
        for (int k = 0; k < 3; k++) begin
            drive(1, 3, 0, 0, 5);
            step();
        end
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (cr_valid) seen++;
        end
        chk("rstflight.cr_count", seen, 0);
        chk("rstflight.flit_count", int'(flit_count), 0);
        chk("rstflight.done", int'(done), 0);
        chk("rstflight.err", int'(err), 0);

`ifdef SINK_PKTLEN_CHECK_EN
        // 17-flit packet: code 6 on the 17th flit
        cfg(5, 5, 1);
        for (int k = 1; k <= 17; k++) begin
            drive(1, 0, (k == 1) ? 1 : 0, (k == 17) ? 1 : 0, 5);
            step();
            chk($sformatf("len17.f%0d.err", k), int'(err), (k == 17) ? 1 : 0);
            if (k == 17) chk("len17.err_code", int'(err_code), 6);
        end
        drive(0, 0, 0, 0, 0);
        cfg(5, 5, 1);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, (k == 1) ? 1 : 0, (k == 4) ? 1 : 0, 5);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        chk("len4.max_pkt_len", int'(max_pkt_len), 4);
        chk("len4.err", int'(err), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/traffic_sink.md
Name: traffic_sink

Overview:
- Ejection-side endpoint for one router: consumes flits leaving the router's local output port, checks them, and returns credits upstream after a programmable delay.
- Counts delivered flits and packets and raises done once the configured packet total has arrived. It is the receive counterpart of the per-node traffic injector.
- One instance per router, driven by the NoC top-level bench.

Parameters:
- NUM_VC, 4, number of virtual channels.
- VC_BITS, 2, width of VC index, equal to log2(NUM_VC).
- DST_BITS, 6, width of node/destination id.
- CNT_BITS, 16, width of flit and packet counters.
- MAX_CREDIT_DELAY, 8, depth of the credit delay line.
- DLY_BITS, 4, width of the credit delay field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_load  in  1  single-cycle pulse; latches the cfg_* inputs and enters RUN.
- cfg_node_id  in  DST_BITS  this node's id.
- cfg_expected  in  CNT_BITS  number of packets expected.
- cfg_credit_delay  in  DLY_BITS  credit return delay D.
- in_valid  in  1  flit present (staging BufferFull).
- in_vc  in  VC_BITS  flit VC.
- in_head  in  1  head flag.
- in_tail  in  1  tail flag.
- in_dst  in  DST_BITS  flit destination.
- cr_valid  out  1  credit return strobe.
- cr_vc  out  VC_BITS  VC being credited.
- flit_count  out  CNT_BITS  flits accepted.
- pkt_count  out  CNT_BITS  tails accepted.
- done  out  1  pkt_count == expected.
- err  out  1  sticky error flag.
- err_code  out  3  first error seen.

Behaviour:
- Reset (rst_n=0 at posedge): top FSM=UNCFG; all per-VC FSMs=IDLE; counters=0; delay line cleared; cr_valid=0, cr_vc=0, done=0, err=0, err_code=0. Reset mid-packet discards all state, including in-flight credits.
- Top FSM transitions:
  - UNCFG -> RUN on cfg_load.
  - RUN -> DONE when pkt_count reaches the latched expected value.
  - cfg_load in RUN or DONE re-latches config, zeroes counters, err and VC FSMs, and goes to RUN.
  - cfg_expected=0 goes directly to DONE on the next cycle.
- Flit acceptance:
  - A flit is accepted when in_valid=1 in RUN or DONE.
  - Flits in UNCFG are dropped with no credit and set err_code=1.
- Per-VC FSM (indexed by in_vc):
  - IDLE + head + tail (single-flit packet): stay IDLE, packet complete.
  - IDLE + head, no tail: go to BODY.
  - BODY + tail: go to IDLE, packet complete.
  - BODY + non-head non-tail: stay in BODY.
  - IDLE + non-head flit: err_code=2, flit still counted and credited, FSM unchanged.
  - BODY + head: err_code=3; the FSM restarts the packet, treated as a new head.
- Destination check: a head flit with in_dst != node_id sets err_code=4, and the packet is still counted.
- Flit from DONE state (extra traffic): err_code=5, still counted and credited.
- Error priority:
  - err_code latches the first error only, and err stays 1 until reset or cfg_load.
  - If one flit triggers several errors in the same cycle, the lowest code wins.
- Counters:
  - flit_count increments by 1 per accepted flit.
  - pkt_count increments on each packet completion.
  - Both saturate at all-ones.
  - done is registered and asserts in the cycle after the increment that reaches expected.
- Credits:
  - A flit accepted at edge N produces cr_valid=1 with cr_vc=flit VC during the cycle after edge N+D, where D=max(cfg_credit_delay,1) and D is clamped to MAX_CREDIT_DELAY.
  - At most one credit is issued per cycle. Credits keep their order.
  - cr_vc=0 whenever cr_valid=0.
  - Changing D via cfg_load flushes the delay line.

Optional Feature:
- SINK_PKTLEN_CHECK_EN:
  - Defined: adds parameter MAX_PKT_FLITS (default 16) and a per-VC flit counter. A packet exceeding MAX_PKT_FLITS flits without a tail sets err_code=6 on the offending flit. Added output max_pkt_len (CNT_BITS) holds the longest completed packet.
  - Undefined: no length counters, no max_pkt_len port, and code 6 is never produced.

Test Plan:
- Reset and config:
  - Stimulus: reset, then cfg_load with node_id=5, expected=2, D=3; send a 3-flit packet on VC1 (dst=5), then a 1-flit packet on VC2.
  - Required response: flit_count=4, pkt_count=2, done=1 one cycle after the final tail; credits appear on VC1,1,1,2, each exactly 3 cycles after its flit; err=0.
- Interleaved VCs:
  - Stimulus: alternate head/body/tail flits on VC0 and VC3 every cycle.
  - Required response: pkt_count=2, err=0, and credits in the same order as the input flits.
- Protocol errors:
  - Stimulus: a body flit on idle VC2.
  - Required response: err=1, err_code=2, flit still credited.
  - Stimulus: a subsequent head flit with dst=7 (node_id=5).
  - Required response: err_code stays 2 (first error latched).
- Delay edges:
  - With D=0: each credit arrives 1 cycle after its flit.
  - With D=15: each credit arrives MAX_CREDIT_DELAY=8 cycles after its flit.
  - Stimulus: reset while 3 credits are in flight.
  - Required response: no cr_valid after reset.
- Unconfigured and done states:
  - Stimulus: a flit before cfg_load.
  - Required response: err_code=1, no credit.
  - Stimulus: after done, send an extra packet.
  - Required response: err_code=5 on a fresh config, flit credited, pkt_count=expected+1.
- Packet length (SINK_PKTLEN_CHECK_EN defined):
  - Stimulus: a 17-flit packet.
  - Required response: err_code=6 on the 17th flit.
  - Stimulus: a valid 4-flit packet.
  - Required response: max_pkt_len=4.
